east_out_port: RTL

//   East egress stage of the router; sits directly downstream of the local-injection router.

---
 rtl/noc_pkg.sv | 34 +++
 rtl/east_out_port_if.sv | 20 ++
 rtl/pkt_fifo.sv | 64 ++++++
 rtl/east_out_port.sv | 144 ++++++++++++++
 4 files changed

// File: rtl/noc_pkg.sv
// ---------------------------------------------------------------------------
// noc_pkg: shared router definitions.
//   PKT_W, DX_MSB, DX_LSB : packet geometry (dx is a signed 4-bit hop count)
//   pkt_t                 : packet word
//   src_e                 : egress arbitration source (local / through)
//   dx_of()               : extract signed dx field
//   hop_dec()             : return packet with dx decremented by one hop
// ---------------------------------------------------------------------------
package noc_pkg;

    localparam int PKT_W  = 16;
    localparam int DX_MSB = 15;
    localparam int DX_LSB = 12;

    typedef logic [PKT_W-1:0] pkt_t;

    typedef enum logic {
        SRC_LOC  = 1'b0,
        SRC_THRU = 1'b1
    } src_e;

    function automatic logic signed [3:0] dx_of(input pkt_t pkt);
        return signed'(pkt[DX_MSB:DX_LSB]);
    endfunction

    // dx=+1 becomes 0 so the next router ejects the packet locally
    function automatic pkt_t hop_dec(input pkt_t pkt);
        pkt_t res;
        res                = pkt;
        res[DX_MSB:DX_LSB] = pkt[DX_MSB:DX_LSB] - 4'd1;
        return res;
    endfunction

endpackage

// File: rtl/east_out_port_if.sv
// ---------------------------------------------------------------------------
// east_out_port_if: one valid/ready packet stream.
//   packet : W-bit packet
//   valid  : packet valid this cycle
//   ready  : receiver can take the packet
// Modports: master (drives packet/valid), slave (drives ready).
// ---------------------------------------------------------------------------
interface east_out_port_if
    import noc_pkg::*;
#(
    parameter int W = PKT_W
);
    logic [W-1:0] packet;
    logic         valid;
    logic         ready;

    modport master (output packet, output valid, input  ready);
    modport slave  (input  packet, input  valid, output ready);

endinterface

// File: rtl/pkt_fifo.sv
// ---------------------------------------------------------------------------
// pkt_fifo: circular packet FIFO with extra-bit pointers.
//   clk, rst : clock, synchronous active-high reset
//   push     : write din (ignored when full)
//   pop      : drop head (ignored when empty)
//   din      : packet in
//   full     : no free entry
//   empty    : no stored entry
//   head     : oldest stored packet
// ---------------------------------------------------------------------------
module pkt_fifo
    import noc_pkg::*;
#(
    parameter int W     = PKT_W,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic         full,
    output logic         empty,
    output logic [W-1:0] head
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem_r [DEPTH];
    logic [AW:0]  wr_ptr_r;
    logic [AW:0]  rd_ptr_r;
    logic         do_push_s;
    logic         do_pop_s;

    // Pointer MSBs differ only when the writer has lapped the reader
    assign full      = (wr_ptr_r[AW] != rd_ptr_r[AW]) && (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
    assign empty     = (wr_ptr_r == rd_ptr_r);
    assign head      = mem_r[rd_ptr_r[AW-1:0]];
    assign do_push_s = push && !full;
    assign do_pop_s  = pop && !empty;

    // Read/write pointer registers
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + (AW+1)'(1);
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + (AW+1)'(1);
            end
        end
    end

    // Storage array; contents are don't-care while the pointers mark them empty
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_r[wr_ptr_r[AW-1:0]] <= din;
        end
    end

endmodule

// File: rtl/east_out_port.sv
// ---------------------------------------------------------------------------
// east_out_port: east egress stage. Buffers local-injected and through
// traffic in two FIFOs, round-robin arbitrates between them and holds the
// winner in a registered valid/ready output.
//   clk, rst : clock, synchronous active-high reset
//   loc      : slave stream from local router (no backpressure upstream)
//   thru     : slave stream from west input port (no backpressure upstream)
//   out      : master stream to the east link
//   drop_cnt : saturating count of dropped packets
// Build option HOP_DEC_EN: decrement dx on output and drop packets with
// dx<=0 on input; otherwise packets pass bit-exact.
// ---------------------------------------------------------------------------
module east_out_port
    import noc_pkg::*;
#(
    parameter int W     = PKT_W,
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
) (
    input  logic                clk,
    input  logic                rst,
    east_out_port_if.slave      loc,
    east_out_port_if.slave      thru,
    east_out_port_if.master     out,
    output logic [CNT_W-1:0]    drop_cnt
);

    localparam logic [CNT_W-1:0] DROP_MAX = {CNT_W{1'b1}};

    logic         loc_full_s,  loc_empty_s,  loc_push_s,  loc_pop_s,  loc_legal_s,  loc_drop_s;
    logic         thru_full_s, thru_empty_s, thru_push_s, thru_pop_s, thru_legal_s, thru_drop_s;
    logic [W-1:0] loc_head_s, thru_head_s, sel_pkt_s;
    logic         load_s, grant_loc_s;
    logic [CNT_W:0]   drop_sum_s;
    logic [CNT_W-1:0] drop_nxt_s;

    src_e         rr_r;
    logic         out_valid_r;
    logic [W-1:0] out_packet_r;
    logic [CNT_W-1:0] drop_cnt_r;

`ifdef HOP_DEC_EN
    assign loc_legal_s  = (dx_of(loc.packet)  > 4'sd0);
    assign thru_legal_s = (dx_of(thru.packet) > 4'sd0);
`else
    assign loc_legal_s  = 1'b1;
    assign thru_legal_s = 1'b1;
`endif

    // ready is from registered FIFO state, so a same-cycle pop never frees room
    assign loc.ready   = !loc_full_s;
    assign thru.ready  = !thru_full_s;
    assign loc_push_s  = loc.valid  && loc_legal_s  && !loc_full_s;
    assign thru_push_s = thru.valid && thru_legal_s && !thru_full_s;
    assign loc_drop_s  = loc.valid  && !(loc_legal_s  && !loc_full_s);
    assign thru_drop_s = thru.valid && !(thru_legal_s && !thru_full_s);

    pkt_fifo #(.W(W), .DEPTH(DEPTH)) u_loc_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (loc_push_s),
        .pop   (loc_pop_s),
        .din   (loc.packet),
        .full  (loc_full_s),
        .empty (loc_empty_s),
        .head  (loc_head_s)
    );

    pkt_fifo #(.W(W), .DEPTH(DEPTH)) u_thru_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (thru_push_s),
        .pop   (thru_pop_s),
        .din   (thru.packet),
        .full  (thru_full_s),
        .empty (thru_empty_s),
        .head  (thru_head_s)
    );

    // Arbitration: rr_r names the source favoured when both FIFOs hold data
    always_comb begin
        load_s      = 1'b0;
        grant_loc_s = 1'b0;
        if (!out_valid_r || out.ready) begin
            load_s = !loc_empty_s || !thru_empty_s;
        end else begin
            load_s = 1'b0;
        end
        if (!loc_empty_s && !thru_empty_s) begin
            case (rr_r)
                SRC_LOC:  grant_loc_s = 1'b1;
                SRC_THRU: grant_loc_s = 1'b0;
                default:  grant_loc_s = 1'b1;
            endcase
        end else begin
            grant_loc_s = !loc_empty_s;
        end
    end

    assign loc_pop_s  = load_s && grant_loc_s;
    assign thru_pop_s = load_s && !grant_loc_s;

`ifdef HOP_DEC_EN
    assign sel_pkt_s = hop_dec(grant_loc_s ? loc_head_s : thru_head_s);
`else
    assign sel_pkt_s = grant_loc_s ? loc_head_s : thru_head_s;
`endif

    // Drop counter next value; inc is at most 2 so overflow shows in the carry bit
    always_comb begin
        drop_sum_s = {1'b0, drop_cnt_r}
                   + (CNT_W+1)'(loc_drop_s)
                   + (CNT_W+1)'(thru_drop_s);
        if (drop_sum_s[CNT_W]) begin
            drop_nxt_s = DROP_MAX;
        end else begin
            drop_nxt_s = drop_sum_s[CNT_W-1:0];
        end
    end

    // Output register, round-robin pointer and drop counter
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_r  <= 1'b0;
            out_packet_r <= '0;
            rr_r         <= SRC_LOC;
            drop_cnt_r   <= '0;
        end else begin
            if (load_s) begin
                out_valid_r  <= 1'b1;
                out_packet_r <= sel_pkt_s;
                rr_r         <= grant_loc_s ? SRC_THRU : SRC_LOC;
            end else if (out.ready) begin
                out_valid_r  <= 1'b0;
            end
            drop_cnt_r <= drop_nxt_s;
        end
    end

    assign out.valid  = out_valid_r;
    assign out.packet = out_packet_r;
    assign drop_cnt   = drop_cnt_r;

endmodule
